// File: rtl/keypad_scanner_if.sv
// Key-event bus from the keypad scanner to the lock FSM.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output key_code, output key_valid, output key_held);
  modport slave  (input  key_code, input  key_valid, input  key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchronizer,
// press/release debounce, ghost rejection and one-pulse-per-press key events.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 8,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  output logic [2:0]        scan_state,
  keypad_scanner_if.master  key_if
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_RELEASE  = 3'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_row_s;
  logic [DW-1:0] r_dwell;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_col;
  logic [3:0]    r_col_out;
  logic [1:0]    r_row;
  logic [3:0]    r_pat;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  logic [3:0]    w_low;
  logic          w_one_low;
  logic          w_all_high;
  logic [1:0]    w_row_idx;
  logic [1:0]    w_col_next;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  assign w_low      = ~r_row_s;
  assign w_one_low  = ($countones(w_low) == 1);
  assign w_all_high = &r_row_s;
  assign w_col_next = r_col + 2'd1;

  // Index of the (single) active row in the synchronized pattern.
  always_comb begin
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_low[i]) w_row_idx = 2'(i);
    end
  end

  // Two-flop synchronizer for the asynchronous row returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'hF;
      r_row_s <= 4'hF;
    end else begin
      r_sync1 <= row_in;
      r_row_s <= r_sync1;
    end
  end

  // Scan / debounce / hold / release state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_SCAN;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_col_out   <= 4'b1110;
      r_row       <= 2'd0;
      r_pat       <= 4'hF;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            if (w_one_low) begin
              r_row   <= w_row_idx;
              r_pat   <= r_row_s;
              r_cnt   <= '0;
              r_state <= ST_DEBOUNCE;
            end else begin
              // Idle or multi-row chord: move on to the next column.
              r_col     <= w_col_next;
              r_col_out <= col_drive(w_col_next);
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        ST_DEBOUNCE: begin
          // A mismatch wins over a completing count.
          if (r_row_s != r_pat) begin
            r_dwell <= '0;
            r_state <= ST_SCAN;
          end else if (r_cnt == CNT_LAST) begin
            r_key_code  <= {r_row, r_col};
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_all_high) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!w_all_high) begin
            r_state <= ST_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_col      <= w_col_next;
            r_col_out  <= col_drive(w_col_next);
            r_dwell    <= '0;
            r_key_held <= 1'b0;
            r_state    <= ST_SCAN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_key_held <= 1'b0;
          r_state    <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_out          = r_col_out;
  assign scan_state       = r_state;
  assign key_if.key_code  = r_key_code;
  assign key_if.key_valid = r_key_valid;
  assign key_if.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the
// column drive; expected key events come from a press-level reference model.
module tb_keypad_scanner;
  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned DEBOUNCE_CNT = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [2:0] scan_state;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .reset_n(reset_n), .row_in(row_in), .col_out(col_out),
    .scan_state(scan_state), .key_if(kif)
  );

  always #5 clk = ~clk;

  // Physical keypad: pressed[r][c] shorts row r to column c.
  logic [3:0] pressed [4];
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r] & ~col_out);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: key_code after the last accepted press.
  logic [3:0] exp_code = 4'd0;

  // Event monitor (sampled on the falling edge).
  int         cyc = 0;
  int         pulse_cnt = 0;
  int         consec = 0;
  int         deb_entry = 0;
  int         last_lat = -1;
  int         rel_scan = 0;
  logic       prev_valid = 1'b0;
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    cyc++;
    if (scan_state == 3'd1 && prev_state != 3'd1) deb_entry = cyc;
    if (kif.key_valid === 1'b1) begin
      pulse_cnt++;
      last_lat = cyc - deb_entry;
      if (prev_valid) consec++;
    end
    if (scan_state == 3'd0 && prev_state == 3'd3) rel_scan++;
    prev_valid = kif.key_valid;
    prev_state = scan_state;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] col_of(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (scan_state == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pulse(input int base, input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (pulse_cnt != base) begin ok = 1'b1; n = k; break; end
    end
  endtask

  task automatic test_reset();
    logic [1:0] c;
    reset_n = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    repeat (3) tick();
    exp_code = 4'd0;
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col_out); end
    checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %h expected 0", kif.key_code); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", kif.key_valid); end
    checks++; if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", kif.key_held); end
    checks++; if (scan_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", scan_state); end
    reset_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      c = 2'((n / SCAN_DIV) % 4);
      checks++;
      if (col_out !== col_of(c)) begin
        errors++; $display("FAIL scan_seq edge %0d: got %b expected %b", n, col_out, col_of(c));
      end
    end
  endtask

  task automatic test_clean_press(input logic [1:0] r, input logic [1:0] c, input int hold);
    bit ok;
    int n;
    int base;
    base = pulse_cnt;
    pressed[r][c] = 1'b1;
    wait_pulse(base, 200, ok, n);
    checks++;
    if (!ok) begin errors++; $display("FAIL press_timeout key %h: no pulse got 0 expected 1", {r, c}); end
    exp_code = {r, c};
    checks++; if (kif.key_code !== exp_code) begin errors++; $display("FAIL press_code: got %h expected %h", kif.key_code, exp_code); end
    checks++; if (last_lat != DEBOUNCE_CNT) begin errors++; $display("FAIL press_latency: got %0d expected %0d", last_lat, DEBOUNCE_CNT); end
    checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", kif.key_held); end
    repeat (hold) tick();
    checks++; if (pulse_cnt != base + 1) begin errors++; $display("FAIL no_repeat: got %0d pulses expected %0d", pulse_cnt - base, 1); end
    checks++; if (scan_state !== 3'd2) begin errors++; $display("FAIL hold_state: got %0d expected 2", scan_state); end
    pressed[r][c] = 1'b0;
    // 2 synchronizer edges, 1 edge to see the release, then DEBOUNCE_CNT edges.
    for (int k = 1; k <= DEBOUNCE_CNT + 3; k++) begin
      tick();
      if (k == DEBOUNCE_CNT + 2) begin
        checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL held_until_release: got %b expected 1", kif.key_held); end
      end
    end
    checks++; if (kif.key_held !== 1'b0) begin errors++; $display("FAIL held_cleared: got %b expected 0", kif.key_held); end
    checks++; if (scan_state !== 3'd0) begin errors++; $display("FAIL release_state: got %0d expected 0", scan_state); end
    checks++; if (col_out !== col_of(c + 2'd1)) begin errors++; $display("FAIL resume_col: got %b expected %b", col_out, col_of(c + 2'd1)); end
  endtask

  task automatic test_bounce(input logic [1:0] r, input logic [1:0] c, input int d);
    bit ok;
    int base;
    base = pulse_cnt;
    pressed[r][c] = 1'b1;
    wait_state(3'd1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_timeout: state got %0d expected 1", scan_state); end
    repeat (d) tick();
    pressed[r][c] = 1'b0;
    repeat (10) tick();
    checks++; if (pulse_cnt != base) begin errors++; $display("FAIL bounce_pulse: got %0d pulses expected 0", pulse_cnt - base); end
    checks++; if (scan_state !== 3'd0) begin errors++; $display("FAIL bounce_state: got %0d expected 0", scan_state); end
    checks++; if (kif.key_code !== exp_code) begin errors++; $display("FAIL bounce_code: got %h expected %h", kif.key_code, exp_code); end
  endtask

  task automatic test_ghost(input logic [1:0] c, input logic [1:0] r0, input logic [1:0] r1);
    int base;
    bit left_scan;
    bit advanced;
    logic [3:0] prev_col;
    base = pulse_cnt;
    left_scan = 1'b0;
    advanced = 1'b0;
    pressed[r0][c] = 1'b1;
    pressed[r1][c] = 1'b1;
    prev_col = col_out;
    for (int k = 0; k < 4 * SCAN_DIV + 4; k++) begin
      tick();
      if (scan_state != 3'd0) left_scan = 1'b1;
      if (prev_col == col_of(c) && col_out == col_of(c + 2'd1)) advanced = 1'b1;
      prev_col = col_out;
    end
    pressed[r0][c] = 1'b0;
    pressed[r1][c] = 1'b0;
    checks++; if (pulse_cnt != base) begin errors++; $display("FAIL ghost_pulse: got %0d pulses expected 0", pulse_cnt - base); end
    checks++; if (left_scan) begin errors++; $display("FAIL ghost_state: got left SCAN=1 expected 0"); end
    checks++; if (!advanced) begin errors++; $display("FAIL ghost_advance: got advance=0 expected 1 (col %0d)", c); end
  endtask

  task automatic test_release_glitch(input logic [1:0] r, input logic [1:0] c);
    bit ok;
    int n;
    int base;
    int base_rel;
    base = pulse_cnt;
    pressed[r][c] = 1'b1;
    wait_pulse(base, 200, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_press_timeout: got 0 pulses expected 1"); end
    exp_code = {r, c};
    repeat (5) tick();
    pressed[r][c] = 1'b0;
    repeat (3) tick();
    pressed[r][c] = 1'b1;
    repeat (6) tick();
    checks++; if (scan_state !== 3'd2) begin errors++; $display("FAIL glitch_state: got %0d expected 2", scan_state); end
    checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL glitch_held: got %b expected 1", kif.key_held); end
    checks++; if (pulse_cnt != base + 1) begin errors++; $display("FAIL glitch_pulse: got %0d pulses expected 1", pulse_cnt - base); end
    base_rel = rel_scan;
    pressed[r][c] = 1'b0;
    wait_state(3'd0, 60, ok);
    repeat (10) tick();
    checks++; if (!ok) begin errors++; $display("FAIL glitch_release_timeout: state got %0d expected 0", scan_state); end
    checks++; if (rel_scan != base_rel + 1) begin errors++; $display("FAIL glitch_release_count: got %0d expected 1", rel_scan - base_rel); end
    checks++; if (pulse_cnt != base + 1) begin errors++; $display("FAIL glitch_total_pulse: got %0d expected 1", pulse_cnt - base); end
  endtask

  task automatic test_reset_mid(input logic [1:0] r, input logic [1:0] c);
    bit ok;
    int n;
    int base;
    pressed[r][c] = 1'b1;
    wait_state(3'd1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: state got %0d expected 1", scan_state); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_code = 4'd0;
    #1;
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL rstmid_col: got %b expected 1110", col_out); end
    checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL rstmid_code: got %h expected 0", kif.key_code); end
    checks++; if (kif.key_held !== 1'b0 || kif.key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got held=%b valid=%b expected 0 0", kif.key_held, kif.key_valid); end
    checks++; if (scan_state !== 3'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", scan_state); end
    repeat (3) tick();
    base = pulse_cnt;
    reset_n = 1'b1;
    wait_pulse(base, 150, ok, n);
    exp_code = {r, c};
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_repress_timeout: got 0 pulses expected 1"); end
    checks++; if (kif.key_code !== exp_code) begin errors++; $display("FAIL rstmid_code2: got %h expected %h", kif.key_code, exp_code); end
    // Scan restarts at column 0, so column c is evaluated at its last dwell cycle.
    checks++; if (n != SCAN_DIV * (int'(c) + 1) + DEBOUNCE_CNT) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", n, SCAN_DIV * (int'(c) + 1) + DEBOUNCE_CNT); end
    pressed[r][c] = 1'b0;
    wait_state(3'd0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle_timeout: state got %0d expected 0", scan_state); end
  endtask

  task automatic test_no_double();
    checks++; if (consec != 0) begin errors++; $display("FAIL valid_back_to_back: got %0d expected 0", consec); end
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] r1;
    test_reset();
    test_clean_press(2'd2, 2'd1, 100);
    for (int i = 0; i < 4; i++) begin
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      test_clean_press(r, c, 20 + int'($urandom_range(0, 60)));
    end
    test_bounce(2'd0, 2'd3, 5);
    for (int i = 0; i < 2; i++) begin
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      test_bounce(r, c, 1 + int'($urandom_range(0, 9)));
    end
    test_ghost(2'd0, 2'd0, 2'd1);
    r  = 2'($urandom_range(0, 3));
    r1 = r + 2'($urandom_range(1, 3));
    test_ghost(2'($urandom_range(0, 3)), r, r1);
    test_release_glitch(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    test_reset_mid(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    test_no_double();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
